// File: rtl/unidade_controle_if.sv
// Handshake bundle between the game control FSM and the rest of the system.
// The FSM side (slave) takes the status inputs and drives the control strobes.
// The system side (master) is the datapath or a testbench.
//   status : iniciar, indice_pronto, jogada_feita, botaoIgualMemoria, rodadaIgualFinal
//   control: zeraA/Rod/R/M/I, registraR/M, contaA/Rod/I, pronto, timeout, db_estado[3:0]
interface unidade_controle_if;
    logic       iniciar;
    logic       indice_pronto;
    logic       jogada_feita;
    logic       botaoIgualMemoria;
    logic       rodadaIgualFinal;

    logic       zeraA, zeraRod, zeraR, zeraM, zeraI;
    logic       registraR, registraM;
    logic       contaA, contaRod, contaI;
    logic       pronto;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        output iniciar, indice_pronto, jogada_feita, botaoIgualMemoria, rodadaIgualFinal,
        input  zeraA, zeraRod, zeraR, zeraM, zeraI, registraR, registraM,
        input  contaA, contaRod, contaI, pronto, timeout, db_estado
    );

    modport slave (
        input  iniciar, indice_pronto, jogada_feita, botaoIgualMemoria, rodadaIgualFinal,
        output zeraA, zeraRod, zeraR, zeraM, zeraI, registraR, registraM,
        output contaA, contaRod, contaI, pronto, timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle.sv
// Moore control FSM for the memory game: clears the datapath, waits for an
// index permutation, waits for a move, compares it, counts hits and rounds,
// and signals the end of the game.
// Ports:
//   clock - rising-edge system clock
//   reset - asynchronous, active-high; forces inicial and clears the move timer
//   bus   - unidade_controle_if.slave (status inputs, control strobes, db_estado)
// Parameter TIMEOUT_CICLOS: clock cycles allowed per move in espera_jogada.
// Macro MINDFOCUS_TIMEOUT_EN: when defined, a move timer sends an expired move
// to estouro (counted as a miss); when undefined, espera_jogada waits forever,
// timeout stays 0 and encoding 11 behaves as an unused code.
module unidade_controle #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input logic            clock,
    input logic            reset,
    unidade_controle_if.slave bus
);

    typedef enum logic [3:0] {
        INICIAL          = 4'd0,
        PREPARACAO       = 4'd1,
        ESPERA_INDICES   = 4'd2,
        REGISTRA_INDICES = 4'd3,
        ESPERA_JOGADA    = 4'd4,
        REGISTRA_JOGADA  = 4'd5,
        COMPARA          = 4'd6,
        ACERTO           = 4'd7,
        PROXIMA_RODADA   = 4'd8,
        VERIFICA_FIM     = 4'd9,
        FIM              = 4'd10,
        ESTOURO          = 4'd11
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= INICIAL;
        else       state_q <= state_d;
    end

`ifdef MINDFOCUS_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    logic [TW-1:0] timer;
    logic          expirou;

    // Held at zero outside espera_jogada, so every entry starts from 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                         timer <= '0;
        else if (state_q != ESPERA_JOGADA) timer <= '0;
        else                               timer <= timer + TW'(1);
    end

    assign expirou = (timer == TW'(TIMEOUT_CICLOS - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CICLOS != 0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL:          if (bus.iniciar) state_d = PREPARACAO;
            PREPARACAO:       state_d = ESPERA_INDICES;
            ESPERA_INDICES:   if (bus.indice_pronto) state_d = REGISTRA_INDICES;
            REGISTRA_INDICES: state_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A move arriving in the expiry cycle still wins.
                if (bus.jogada_feita) state_d = REGISTRA_JOGADA;
`ifdef MINDFOCUS_TIMEOUT_EN
                else if (expirou)     state_d = ESTOURO;
`endif
            end
            REGISTRA_JOGADA:  state_d = COMPARA;
            COMPARA:          state_d = bus.botaoIgualMemoria ? ACERTO : PROXIMA_RODADA;
            ACERTO:           state_d = PROXIMA_RODADA;
            PROXIMA_RODADA:   state_d = VERIFICA_FIM;
            // Sampled one cycle after contaRod so the updated round count is seen.
            VERIFICA_FIM:     state_d = bus.rodadaIgualFinal ? FIM : ESPERA_INDICES;
            FIM:              if (bus.iniciar) state_d = PREPARACAO;
`ifdef MINDFOCUS_TIMEOUT_EN
            ESTOURO:          state_d = PROXIMA_RODADA;
`endif
            default:          state_d = INICIAL;
        endcase
    end

    // Moore outputs: decoded from state_q only.
    always_comb begin
        bus.zeraA     = 1'b0;
        bus.zeraRod   = 1'b0;
        bus.zeraR     = 1'b0;
        bus.zeraM     = 1'b0;
        bus.zeraI     = 1'b0;
        bus.registraR = 1'b0;
        bus.registraM = 1'b0;
        bus.contaA    = 1'b0;
        bus.contaRod  = 1'b0;
        bus.contaI    = 1'b0;
        bus.pronto    = 1'b0;
        bus.timeout   = 1'b0;
        case (state_q)
            PREPARACAO: begin
                bus.zeraA   = 1'b1;
                bus.zeraRod = 1'b1;
                bus.zeraR   = 1'b1;
                bus.zeraM   = 1'b1;
                bus.zeraI   = 1'b1;
            end
            ESPERA_INDICES:   bus.contaI    = 1'b1;
            REGISTRA_INDICES: bus.registraM = 1'b1;
            ESPERA_JOGADA:    bus.contaI    = 1'b1;
            REGISTRA_JOGADA:  bus.registraR = 1'b1;
            ACERTO:           bus.contaA    = 1'b1;
            PROXIMA_RODADA:   bus.contaRod  = 1'b1;
            FIM:              bus.pronto    = 1'b1;
`ifdef MINDFOCUS_TIMEOUT_EN
            ESTOURO:          bus.timeout   = 1'b1;
`endif
            default: ;
        endcase
    end

    assign bus.db_estado = state_q;

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    unidade_controle_if bus ();

    unidade_controle #(.TIMEOUT_CICLOS(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Packed view of the control outputs:
    // [11]zeraA [10]zeraRod [9]zeraR [8]zeraM [7]zeraI [6]registraR
    // [5]registraM [4]contaA [3]contaRod [2]contaI [1]pronto [0]timeout
    function automatic logic [11:0] outv();
        return {bus.zeraA, bus.zeraRod, bus.zeraR, bus.zeraM, bus.zeraI,
                bus.registraR, bus.registraM, bus.contaA, bus.contaRod,
                bus.contaI, bus.pronto, bus.timeout};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.db_estado !== 4'd0 || outv() !== 12'h000) begin
            errors++;
            $display("FAIL reset_held: state=%0d outs=%h, expected state=0 outs=000", bus.db_estado, outv());
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.db_estado !== 4'd0 || outv() !== 12'h000) begin
            errors++;
            $display("FAIL reset_idle: state=%0d outs=%h, expected state=0 outs=000", bus.db_estado, outv());
        end
    endtask

    task automatic test_start();
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
        checks++;
        if (bus.db_estado !== 4'd1 || outv() !== 12'hF80) begin
            errors++;
            $display("FAIL start_prep: state=%0d outs=%h, expected state=1 outs=f80", bus.db_estado, outv());
        end
        step();
        checks++;
        if (bus.db_estado !== 4'd2 || outv() !== 12'h004) begin
            errors++;
            $display("FAIL start_wait_idx: state=%0d outs=%h, expected state=2 outs=004", bus.db_estado, outv());
        end
    endtask

    // iniciar and jogada_feita have no effect while waiting for indices.
    task automatic test_ignored_inputs();
        bus.iniciar      = 1'b1;
        bus.jogada_feita = 1'b1;
        step();
        bus.iniciar      = 1'b0;
        bus.jogada_feita = 1'b0;
        checks++;
        if (bus.db_estado !== 4'd2 || outv() !== 12'h004) begin
            errors++;
            $display("FAIL ignored_inputs: state=%0d outs=%h, expected state=2 outs=004", bus.db_estado, outv());
        end
    endtask

    // One round from espera_indices; 'hit' drives the comparison, 'last' the final-round flag.
    task automatic test_round(input bit hit, input bit last);
        bus.indice_pronto = 1'b1;
        step();
        bus.indice_pronto = 1'b0;
        checks++;
        if (bus.db_estado !== 4'd3 || outv() !== 12'h020) begin
            errors++;
            $display("FAIL round_reg_idx: state=%0d outs=%h, expected state=3 outs=020", bus.db_estado, outv());
        end
        step();
        checks++;
        if (bus.db_estado !== 4'd4 || outv() !== 12'h004) begin
            errors++;
            $display("FAIL round_wait_move: state=%0d outs=%h, expected state=4 outs=004", bus.db_estado, outv());
        end
        bus.jogada_feita      = 1'b1;
        bus.botaoIgualMemoria = hit;
        step();
        bus.jogada_feita = 1'b0;
        checks++;
        if (bus.db_estado !== 4'd5 || outv() !== 12'h040) begin
            errors++;
            $display("FAIL round_reg_move: state=%0d outs=%h, expected state=5 outs=040", bus.db_estado, outv());
        end
        step();
        checks++;
        if (bus.db_estado !== 4'd6 || outv() !== 12'h000) begin
            errors++;
            $display("FAIL round_compare: state=%0d outs=%h, expected state=6 outs=000", bus.db_estado, outv());
        end
        step();
        if (hit) begin
            checks++;
            if (bus.db_estado !== 4'd7 || outv() !== 12'h010) begin
                errors++;
                $display("FAIL round_hit: state=%0d outs=%h, expected state=7 outs=010", bus.db_estado, outv());
            end
            step();
        end
        bus.botaoIgualMemoria = 1'b0;
        checks++;
        if (bus.db_estado !== 4'd8 || outv() !== 12'h008) begin
            errors++;
            $display("FAIL round_next: state=%0d outs=%h, expected state=8 outs=008", bus.db_estado, outv());
        end
        bus.rodadaIgualFinal = last;
        step();
        checks++;
        if (bus.db_estado !== 4'd9 || outv() !== 12'h000) begin
            errors++;
            $display("FAIL round_check_end: state=%0d outs=%h, expected state=9 outs=000", bus.db_estado, outv());
        end
        step();
        bus.rodadaIgualFinal = 1'b0;
        checks++;
        if (last ? (bus.db_estado !== 4'd10 || outv() !== 12'h002)
                 : (bus.db_estado !== 4'd2  || outv() !== 12'h004)) begin
            errors++;
            $display("FAIL round_after_check: state=%0d outs=%h, expected state=%0d", bus.db_estado, outv(), last ? 10 : 2);
        end
    endtask

    task automatic test_fim_restart();
        step();
        checks++;
        if (bus.db_estado !== 4'd10 || outv() !== 12'h002) begin
            errors++;
            $display("FAIL fim_hold: state=%0d outs=%h, expected state=10 outs=002", bus.db_estado, outv());
        end
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
        checks++;
        if (bus.db_estado !== 4'd1 || outv() !== 12'hF80) begin
            errors++;
            $display("FAIL fim_restart: state=%0d outs=%h, expected state=1 outs=f80", bus.db_estado, outv());
        end
        step();
    endtask

    task automatic test_timeout();
        bus.indice_pronto = 1'b1;
        step();
        bus.indice_pronto = 1'b0;
        step();
`ifdef MINDFOCUS_TIMEOUT_EN
        // No move: 8 cycles in state 4, then estouro for one cycle, then proxima_rodada.
        for (int i = 1; i < 8; i++) step();
        checks++;
        if (bus.db_estado !== 4'd4) begin
            errors++;
            $display("FAIL timeout_still_waiting: state=%0d, expected 4", bus.db_estado);
        end
        step();
        checks++;
        if (bus.db_estado !== 4'd11 || outv() !== 12'h001) begin
            errors++;
            $display("FAIL timeout_estouro: state=%0d outs=%h, expected state=11 outs=001", bus.db_estado, outv());
        end
        step();
        checks++;
        if (bus.db_estado !== 4'd8 || outv() !== 12'h008) begin
            errors++;
            $display("FAIL timeout_miss: state=%0d outs=%h, expected state=8 outs=008", bus.db_estado, outv());
        end
        step();
        step();
        // Move arrives in the expiry cycle: it must win.
        bus.indice_pronto = 1'b1;
        step();
        bus.indice_pronto = 1'b0;
        step();
        for (int i = 1; i < 8; i++) step();
        bus.jogada_feita = 1'b1;
        step();
        bus.jogada_feita = 1'b0;
        checks++;
        if (bus.db_estado !== 4'd5 || outv() !== 12'h040) begin
            errors++;
            $display("FAIL timeout_race: state=%0d outs=%h, expected state=5 outs=040", bus.db_estado, outv());
        end
`else
        // Without the timer the FSM waits indefinitely and timeout never rises.
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (bus.db_estado !== 4'd4 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL no_timeout_wait: cycle=%0d state=%0d timeout=%b, expected state=4 timeout=0", i, bus.db_estado, bus.timeout);
            end
        end
        bus.jogada_feita = 1'b1;
        step();
        bus.jogada_feita = 1'b0;
        checks++;
        if (bus.db_estado !== 4'd5) begin
            errors++;
            $display("FAIL no_timeout_move: state=%0d, expected 5", bus.db_estado);
        end
`endif
    endtask

    // Continues from registra_jogada; reset lands asynchronously in compara.
    task automatic test_reset_mid();
        step();
        checks++;
        if (bus.db_estado !== 4'd6) begin
            errors++;
            $display("FAIL reset_mid_setup: state=%0d, expected 6", bus.db_estado);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.db_estado !== 4'd0 || outv() !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_async: state=%0d outs=%h, expected state=0 outs=000", bus.db_estado, outv());
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (bus.db_estado !== 4'd0 || outv() !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_after: state=%0d outs=%h, expected state=0 outs=000", bus.db_estado, outv());
        end
    endtask

    initial begin
        checks                = 0;
        errors                = 0;
        clock                 = 1'b0;
        reset                 = 1'b1;
        bus.iniciar           = 1'b0;
        bus.indice_pronto     = 1'b0;
        bus.jogada_feita      = 1'b0;
        bus.botaoIgualMemoria = 1'b0;
        bus.rodadaIgualFinal  = 1'b0;

        test_reset();
        test_start();
        test_ignored_inputs();
        test_round(1'b1, 1'b0);
        test_round(1'b0, 1'b0);
        test_round(1'b1, 1'b1);
        test_fim_restart();
        test_timeout();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
